// File: rtl/dcache_if.sv
// dcache_if: CPU load/store port plus block-wide memory port of the data cache.
//   slave  (cache side): takes read/write/address/writedata and mem_readdata/mem_busywait,
//                        drives readdata/busywait and mem_read/mem_write/mem_address/mem_writedata.
//   master (CPU + memory side): the mirror image.
interface dcache_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4
);
  localparam int OFF_W = $clog2(WORDS);
  logic                    read;
  logic                    write;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       writedata;
  logic [DATA_W-1:0]       readdata;
  logic                    busywait;
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_W-OFF_W-1:0] mem_address;
  logic [DATA_W*WORDS-1:0] mem_writedata;
  logic [DATA_W*WORDS-1:0] mem_readdata;
  logic                    mem_busywait;
  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative write-back/write-allocate data cache with per-set LRU.
//   clk_i, rst_ni (async, active-low); bus: dcache_if.slave (CPU port + block memory port);
//   hit_count_o / miss_count_o: saturating first-try hit and miss counters.
module dcache_2way #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dcache_if.slave          bus,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W * WORDS;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t           state_q;
  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [BLK_W-1:0] data_q [2][SETS];
  logic [BLK_W-1:0] fill_q;
  logic [TAG_W-1:0] vtag_q;
  logic             victim_q, replay_q, mem_read_q, mem_write_q;
  logic [CNT_W-1:0] hit_q, miss_q;
  logic [TAG_W-1:0] tag_a;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             req, hit0, hit1, hit, idle_hit, victim_d;
  assign tag_a    = bus.address[ADDR_W-1 -: TAG_W];
  assign idx      = bus.address[OFF_W +: IDX_W];
  assign off      = bus.address[OFF_W-1:0];
  assign req      = bus.read | bus.write;
  assign hit0     = valid_q[0][idx] && tag_q[0][idx] == tag_a;
  assign hit1     = valid_q[1][idx] && tag_q[1][idx] == tag_a;
  assign hit      = hit0 | hit1;
  assign idle_hit = state_q == IDLE && req && hit;
  // Fill an empty way before evicting anything; way 0 is preferred.
  assign victim_d = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign bus.busywait      = state_q != IDLE || (req && !hit);
  assign bus.readdata      = idle_hit && !bus.write ? data_q[hit1][idx][off*DATA_W +: DATA_W] : '0;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = {mem_write_q ? vtag_q : tag_a, idx};
  assign bus.mem_writedata = data_q[victim_q][idx];
  assign hit_count_o       = hit_q;
  assign miss_count_o      = miss_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      valid_q     <= '{default: '0};
      dirty_q     <= '{default: '0};
      lru_q       <= '0;
      replay_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      victim_q    <= 1'b0;
      vtag_q      <= '0;
      fill_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          replay_q <= 1'b0;
          if (idle_hit) begin
            lru_q[idx] <= ~hit1;
            if (bus.write) dirty_q[hit1][idx] <= 1'b1;
            // The replayed access after a fill is not a first-try hit.
            if (!replay_q && ~&hit_q) hit_q <= hit_q + CNT_W'(1);
          end else if (req) begin
            victim_q <= victim_d;
            vtag_q   <= tag_q[victim_d][idx];
            if (~&miss_q) miss_q <= miss_q + CNT_W'(1);
            if (dirty_q[victim_d][idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: if (!bus.mem_busywait) begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b1;
          state_q     <= FETCH;
        end
        FETCH: if (!bus.mem_busywait) begin
          mem_read_q <= 1'b0;
          fill_q     <= bus.mem_readdata;
          state_q    <= UPDATE;
        end
        UPDATE: begin
          valid_q[victim_q][idx] <= 1'b1;
          dirty_q[victim_q][idx] <= 1'b0;
          lru_q[idx]             <= ~victim_q;
          // Only flag a replay if the CPU is still waiting for this access.
          replay_q               <= req;
          state_q                <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (idle_hit && bus.write) data_q[hit1][idx][off*DATA_W +: DATA_W] <= bus.writedata;
    if (state_q == UPDATE) begin
      data_q[victim_q][idx] <= fill_q;
      tag_q[victim_q][idx]  <= tag_a;
    end
  end
endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: scoreboard bench for dcache_2way with a latency-programmable block memory.
module tb_dcache_2way;
  typedef struct {bit wr; logic [7:0] a; logic [7:0] d; int busy;} exp_t;
  typedef struct {bit wr; logic [5:0] addr; logic [31:0] data;} mem_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  dcache_if bus ();
  dcache_if b2 ();
  logic [15:0] hit_c, miss_c;
  logic [3:0]  hit_s, miss_s;
  dcache_2way dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus), .hit_count_o(hit_c), .miss_count_o(miss_c));
  dcache_2way #(.CNT_W(4)) dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(b2), .hit_count_o(hit_s), .miss_count_o(miss_s));
  assign b2.read         = bus.read;
  assign b2.write        = bus.write;
  assign b2.address      = bus.address;
  assign b2.writedata    = bus.writedata;
  assign b2.mem_readdata = bus.mem_readdata;
  assign b2.mem_busywait = bus.mem_busywait;
  int checks = 0, errors = 0;
  int lat = 2, mcnt = 0, busy_n = 0, wb_n = 0, rd_n = 0;
  bit track = 0;
  logic [31:0] mem [64];
  logic [7:0]  exp_mem [256];
  exp_t sbq[$];
  mem_t mq[$];
  exp_t e_m;
  mem_t m_m;
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && mcnt < lat;
  assign bus.mem_readdata = mem[bus.mem_address];
  always @(posedge clk) begin
    mcnt <= ((bus.mem_read || bus.mem_write) && bus.mem_busywait) ? mcnt + 1 : 0;
    if (bus.mem_write && !bus.mem_busywait) mem[bus.mem_address] <= bus.mem_writedata;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // CPU-side monitor: counts stall cycles and pops one expectation per completed access.
  always @(negedge clk) begin
    if (!rst_n || !(bus.read || bus.write)) busy_n = 0;
    else if (bus.busywait) busy_n++;
    else if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected completion at 0x%0h", bus.address);
    end else begin
      e_m = sbq.pop_front();
      chk($sformatf("busy cycles @%0h", e_m.a), busy_n, e_m.busy);
      if (!e_m.wr) chk($sformatf("readdata @%0h", e_m.a), bus.readdata, e_m.d);
      busy_n = 0;
    end
  end
  // Memory-side monitor: strobe exclusivity, transfer counts, and tracked transfer contents.
  always @(negedge clk) if (rst_n) begin
    if (bus.mem_read && bus.mem_write) begin
      errors++;
      $display("FAIL strobes both high at 0x%0h", bus.mem_address);
    end
    if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
      if (bus.mem_write) wb_n++;
      else rd_n++;
      if (track) begin
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL unexpected mem op at 0x%0h", bus.mem_address);
        end else begin
          m_m = mq.pop_front();
          chk("mem op is write", 32'(bus.mem_write), 32'(m_m.wr));
          chk("mem_address", 32'(bus.mem_address), 32'(m_m.addr));
          if (m_m.wr) chk("mem_writedata", bus.mem_writedata, m_m.data);
        end
      end
    end
  end
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d, input int busy);
    sbq.push_back(exp_t'{wr, a, wr ? d : exp_mem[a], busy});
    if (wr) exp_mem[a] = d;
    @(posedge clk); #1;
    bus.read = !wr; bus.write = wr; bus.address = a; bus.writedata = d;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (!bus.busywait) break;
      if (i > 100) begin
        errors++;
        $display("FAIL timeout @%0h busywait=%0b required 0", a, bus.busywait);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
    @(posedge clk); #1;
    bus.read = 0; bus.write = 0;
  endtask
  initial begin
    int n, wb0;
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    for (int a = 0; a < 256; a++) exp_mem[a] = 8'(a) ^ 8'h5A;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) mem[b][k*8 +: 8] = 8'(b*4 + k) ^ 8'h5A;
    repeat (2) @(posedge clk); #1;
    chk("reset hit_count", 32'(hit_c), 0);
    chk("reset miss_count", 32'(miss_c), 0);
    chk("reset busywait", 32'(bus.busywait), 0);
    chk("reset readdata", 32'(bus.readdata), 0);
    chk("reset mem_read", 32'(bus.mem_read), 0);
    chk("reset mem_write", 32'(bus.mem_write), 0);
    @(negedge clk); rst_n = 1;
    // Cold miss with a slow memory, then hits on the filled block.
    lat = 6; track = 1;
    mq.push_back(mem_t'{1'b0, 6'h00, 32'h0});
    access(0, 8'h00, 8'h00, 9);
    chk("miss after cold read", 32'(miss_c), 1);
    chk("hit after cold read", 32'(hit_c), 0);
    lat = 2;
    for (int i = 1; i < 4; i++) access(0, 8'(i), 8'h00, 0);
    chk("hit after block hits", 32'(hit_c), 3);
    // Fill the other way, touch way 0, then evict the dirty LRU way.
    mq.push_back(mem_t'{1'b0, 6'h08, 32'h0});
    access(1, 8'h20, 8'hAB, 5);
    access(0, 8'h00, 8'h00, 0);
    mq.push_back(mem_t'{1'b1, 6'h08, 32'h79787BAB});
    mq.push_back(mem_t'{1'b0, 6'h10, 32'h0});
    access(0, 8'h40, 8'h00, 8);
    chk("mem ops pending", 32'(mq.size()), 0);
    track = 0;
    chk("hit after lru eviction", 32'(hit_c), 4);
    chk("miss after lru eviction", 32'(miss_c), 3);
    // Twenty hits across both ways: the 4-bit counter saturates.
    for (int i = 0; i < 20; i++) access(0, 8'((i & 1) ? 8'h40 + (i >> 1) % 4 : (i >> 1) % 4), 8'h00, 0);
    chk("hit after 20 hits", 32'(hit_c), 24);
    chk("small hit saturated", 32'(hit_s), 15);
    chk("small miss", 32'(miss_s), 3);
    // Sweep: dirty every line, then evict all of them, then read them back.
    wb0 = wb_n;
    for (int s = 0; s < 4; s++)
      for (int t = 8; t < 10; t++) access(1, 8'(t*16 + s*4), 8'(8'hC0 + s*2 + t - 8), 5);
    for (int s = 0; s < 4; s++)
      for (int t = 10; t < 12; t++) access(0, 8'(t*16 + s*4), 8'h00, 8);
    chk("write-backs in sweep", 32'(wb_n - wb0), 8);
    chk("miss after sweep", 32'(miss_c), 19);
    for (int s = 0; s < 4; s++)
      for (int t = 8; t < 10; t++) access(0, 8'(t*16 + s*4), 8'h00, 5);
    chk("miss after read-back", 32'(miss_c), 27);
    chk("hit after read-back", 32'(hit_c), 24);
    chk("small miss saturated", 32'(miss_s), 15);
    chk("small hit held", 32'(hit_s), 15);
    // Request withdrawn during FETCH: the fill still lands, no hit is counted.
    @(posedge clk); #1;
    bus.read = 1; bus.address = 8'hC4;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_read && n < 50);
    chk("mem_read raised", 32'(bus.mem_read), 1);
    @(posedge clk); #1;
    bus.read = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busywait && n < 50);
    chk("idle after drop", 32'(bus.busywait), 0);
    chk("hit after drop", 32'(hit_c), 24);
    chk("miss after drop", 32'(miss_c), 28);
    access(0, 8'hC4, 8'h00, 0);
    chk("hit on dropped fill", 32'(hit_c), 25);
    // Reset in the middle of a write-back.
    access(1, 8'h08, 8'h77, 5);
    access(1, 8'h18, 8'h66, 5);
    @(posedge clk); #1;
    bus.read = 1; bus.address = 8'hD8;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_write && n < 50);
    chk("mem_write raised", 32'(bus.mem_write), 1);
    wb0 = wb_n;
    #2 rst_n = 0;
    #1;
    chk("mem_write on reset", 32'(bus.mem_write), 0);
    chk("mem_read on reset", 32'(bus.mem_read), 0);
    chk("hit on reset", 32'(hit_c), 0);
    chk("miss on reset", 32'(miss_c), 0);
    chk("small hit on reset", 32'(hit_s), 0);
    bus.read = 0;
    @(negedge clk); rst_n = 1;
    // The dirty data was never written back, so memory still holds the originals.
    exp_mem[8'h08] = 8'h08 ^ 8'h5A;
    exp_mem[8'h18] = 8'h18 ^ 8'h5A;
    access(0, 8'h08, 8'h00, 5);
    access(0, 8'h18, 8'h00, 5);
    chk("miss after reset", 32'(miss_c), 2);
    chk("hit after reset", 32'(hit_c), 0);
    chk("write-backs after reset", 32'(wb_n - wb0), 0);
    chk("scoreboard drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
